// File: rtl/sound_ctrl_decoder_pkg.sv
// Shared definitions for the sound control decoder: bus geometry, voice slot
// layout, FSM state encoding and slot access helpers.
// No ports (package); imported by the decoder, its stabilizer and interface.
package synth_pkg;

    localparam int NUM_VOICES = 8;
    localparam int SLOT_W     = 11;
    localparam int BUS_W      = NUM_VOICES * SLOT_W;

    // Field offsets inside one voice slot
    localparam int ENABLE_BIT = 10;
    localparam int WAVE_LSB   = 7;
    localparam int NOTE_LSB   = 0;

    localparam int VOICE_W = 3;
    localparam int WAVE_W  = 3;
    localparam int NOTE_W  = 7;

    // Packed MSB-first so that en lands on ENABLE_BIT, wave on WAVE_LSB+,
    // note on NOTE_LSB+.
    typedef struct packed {
        logic              en;
        logic [WAVE_W-1:0] wave;
        logic [NOTE_W-1:0] note;
    } voice_slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } fsm_state_t;

    function automatic int slot_base(input logic [VOICE_W-1:0] v);
        return int'(v) * SLOT_W;
    endfunction

    function automatic voice_slot_t get_slot(input logic [BUS_W-1:0] bus,
                                             input logic [VOICE_W-1:0] v);
        return voice_slot_t'(bus[slot_base(v) +: SLOT_W]);
    endfunction

    // A voice needs an event when it turns on/off, or when it stays on and
    // its note or waveform changes. Fields of a disabled voice are don't-care.
    function automatic logic slot_differs(input voice_slot_t a, input voice_slot_t b);
        return (a.en != b.en) ||
               (a.en && b.en && ((a.note != b.note) || (a.wave != b.wave)));
    endfunction

endpackage

// File: rtl/sound_ctrl_decoder_if.sv
// Voice event handshake between the decoder (master) and the voice engine (slave).
// Signals: evt_valid/evt_ready handshake, evt_voice/evt_on/evt_note/evt_wave payload.
// Payload is held stable by the master while evt_valid is high and evt_ready is low.
interface sound_ctrl_decoder_if;
    import synth_pkg::*;

    logic               evt_valid;
    logic               evt_ready;
    logic [VOICE_W-1:0] evt_voice;
    logic               evt_on;
    logic [NOTE_W-1:0]  evt_note;
    logic [WAVE_W-1:0]  evt_wave;

    modport master (
        output evt_valid, evt_voice, evt_on, evt_note, evt_wave,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_voice, evt_on, evt_note, evt_wave,
        output evt_ready
    );

endinterface

// File: rtl/sound_ctrl_decoder_stabilizer.sv
// Registers an asynchronous-ish control bus and flags it stable once it has held
// for STABLE_CYCLES consecutive cycles. Ports: clk, reset, bus_in -> cand, stable.
// Latency: one input register plus STABLE_CYCLES+1 cycles to stable; no backpressure.
module ctrl_bus_stabilizer #(
    parameter int WIDTH         = 88,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] cand,
    output logic             stable
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

    logic [WIDTH-1:0] bus_q;
    logic [3:0]       cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_q <= '0;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            bus_q <= bus_in;
            if (bus_q != cand) begin
                // Any change restarts the hold count against the new value
                cand <= bus_q;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign stable = (cnt == CNT_MAX);

endmodule

// File: rtl/sound_ctrl_decoder.sv
// Decodes the 8-voice sound control bus into per-voice note-on/off events.
// Ports: clk, reset, sound_ctrl_bus in; evt (master handshake), voice_active out.
// First event STABLE_CYCLES+4 cycles after a bus change; payload held until evt_ready.
module sound_ctrl_decoder
    import synth_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BUS_W-1:0]             sound_ctrl_bus,
    sound_ctrl_decoder_if.master         evt,
    output logic [NUM_VOICES-1:0]        voice_active
);

    logic [BUS_W-1:0]   cand;
    logic               stable;

    fsm_state_t         state, state_d;
    logic [VOICE_W-1:0] idx, idx_d;
    logic [BUS_W-1:0]   snap, snap_d;
    logic [BUS_W-1:0]   committed, committed_d;

    voice_slot_t        snap_slot;
    voice_slot_t        comm_slot;
    logic               emit;

    ctrl_bus_stabilizer #(
        .WIDTH         (BUS_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .clk    (clk),
        .reset  (reset),
        .bus_in (sound_ctrl_bus),
        .cand   (cand),
        .stable (stable)
    );

    assign snap_slot = get_slot(snap, idx);
    assign comm_slot = get_slot(committed, idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            snap      <= '0;
            committed <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            snap      <= snap_d;
            committed <= committed_d;
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        snap_d      = snap;
        committed_d = committed;

        unique case (state)
            ST_IDLE: begin
                // snap is only reloaded here, so bus activity during a scan
                // cannot alter events already in flight
                if (stable && (cand != committed)) begin
                    snap_d  = cand;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (slot_differs(snap_slot, comm_slot)) begin
                    state_d = ST_EMIT;
                end else begin
                    // Silent update keeps fields of disabled voices in step
                    committed_d[slot_base(idx) +: SLOT_W] = snap_slot;
                    if (idx == VOICE_W'(NUM_VOICES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx + 3'd1;
                        state_d = ST_SCAN;
                    end
                end
            end

            ST_EMIT: begin
                if (evt.evt_ready) begin
                    committed_d[slot_base(idx) +: SLOT_W] = snap_slot;
                    if (idx == VOICE_W'(NUM_VOICES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx + 3'd1;
                        state_d = ST_SCAN;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Payload comes straight from frozen snap/idx, so it cannot move during a stall
    assign emit          = (state == ST_EMIT);
    assign evt.evt_valid = emit;
    assign evt.evt_voice = emit ? idx : '0;
    assign evt.evt_on    = emit & snap_slot.en;
    assign evt.evt_note  = emit ? snap_slot.note : '0;
    assign evt.evt_wave  = emit ? snap_slot.wave : '0;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_active
        assign voice_active[v] = committed[v*SLOT_W + ENABLE_BIT];
    end

endmodule

// File: tb/tb_sound_ctrl_decoder.sv
module tb_sound_ctrl_decoder;
    import synth_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [BUS_W-1:0] bus;
    logic [7:0]       voice_active;

    int n_cmp  = 0;
    int n_fail = 0;

    sound_ctrl_decoder_if ev();

    sound_ctrl_decoder #(.STABLE_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .sound_ctrl_bus (bus),
        .evt            (ev.master),
        .voice_active   (voice_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] set_slot(input logic [BUS_W-1:0] b, input int v,
                                                  input logic en, input logic [2:0] wave,
                                                  input logic [6:0] note);
        logic [BUS_W-1:0] r;
        r = b;
        r[v*SLOT_W +: SLOT_W] = {en, wave, note};
        return r;
    endfunction

    // Waits (bounded) for evt_valid, then checks the payload against expectation
    task automatic expect_evt(input string tag, input logic [2:0] voice, input logic on,
                              input logic [6:0] note, input logic [2:0] wave);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ev.evt_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_seen"}, 32'(got), 32'd1);
        if (got)
            check({tag, "_payload"},
                  32'({ev.evt_voice, ev.evt_on, ev.evt_note, ev.evt_wave}),
                  32'({voice, on, note, wave}));
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            if (ev.evt_valid !== 1'b0) c++;
            tick();
        end
    endtask

    logic [BUS_W-1:0] bus_a, bus_b;
    int               c;

    initial begin
        reset        = 1'b1;
        bus          = '0;
        ev.evt_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(ev.evt_valid), 0);
        check("rst_payload", 32'({ev.evt_voice, ev.evt_on, ev.evt_note, ev.evt_wave}), 0);
        check("rst_active", 32'(voice_active), 0);

        reset = 1'b0;
        repeat (8) tick();
        check("idle_no_evt", 32'(ev.evt_valid), 0);

        // Voice 0 on: event exactly in cycle 8 after the bus change
        bus = set_slot(bus, 0, 1'b1, 3'd2, 7'd60);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("lat_early", 32'(ev.evt_valid), 0);
        end
        tick();
        check("lat_cycle8", 32'(ev.evt_valid), 1);
        check("v0_on_payload", 32'({ev.evt_voice, ev.evt_on, ev.evt_note, ev.evt_wave}),
              32'({3'd0, 1'b1, 7'd60, 3'd2}));
        tick();
        check("v0_on_drop", 32'(ev.evt_valid), 0);
        check("v0_on_active", 32'(voice_active), 32'h01);
        count_valid(20, c);
        check("v0_on_single", 32'(c), 0);

        // Voice 0 off keeps snap note/wave
        bus = set_slot(bus, 0, 1'b0, 3'd2, 7'd60);
        expect_evt("v0_off", 3'd0, 1'b0, 7'd60, 3'd2);
        tick();
        check("v0_off_active", 32'(voice_active), 32'h00);
        count_valid(20, c);
        check("v0_off_single", 32'(c), 0);

        // Voices 2 and 5 together with a 10-cycle stall on voice 2
        ev.evt_ready = 1'b0;
        bus = set_slot(bus, 2, 1'b1, 3'd1, 7'd64);
        bus = set_slot(bus, 5, 1'b1, 3'd3, 7'd67);
        expect_evt("v2_stall", 3'd2, 1'b1, 7'd64, 3'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("v2_held", 32'({ev.evt_valid, ev.evt_voice, ev.evt_on, ev.evt_note, ev.evt_wave}),
                  32'({1'b1, 3'd2, 1'b1, 7'd64, 3'd1}));
        end
        check("v2_stall_active", 32'(voice_active), 32'h00);
        ev.evt_ready = 1'b1;
        tick();
        check("v2_drop", 32'(ev.evt_valid), 0);
        check("v2_active", 32'(voice_active), 32'h04);
        expect_evt("v5", 3'd5, 1'b1, 7'd67, 3'd3);
        tick();
        check("v25_active", 32'(voice_active), 32'h24);

        // Bus toggling every 2 cycles never stabilizes
        bus_a = set_slot(bus, 7, 1'b1, 3'd0, 7'd70);
        bus_b = set_slot(bus, 6, 1'b1, 3'd4, 7'd72);
        c = 0;
        for (int k = 0; k < 20; k++) begin
            int c2;
            bus = k[0] ? bus_b : bus_a;
            count_valid(2, c2);
            c += c2;
        end
        check("toggle_no_evt", 32'(c), 0);
        expect_evt("toggle_final", 3'd6, 1'b1, 7'd72, 3'd4);
        tick();
        count_valid(30, c);
        check("toggle_only_final", 32'(c), 0);
        check("toggle_active", 32'(voice_active), 32'h64);

        // Disabled voice note change is silent, enable picks up the new note
        bus = set_slot(bus, 3, 1'b0, 3'd0, 7'd50);
        count_valid(30, c);
        check("v3_silent", 32'(c), 0);
        check("v3_silent_active", 32'(voice_active), 32'h64);
        bus = set_slot(bus, 3, 1'b1, 3'd0, 7'd50);
        expect_evt("v3_on", 3'd3, 1'b1, 7'd50, 3'd0);
        tick();
        check("v3_active", 32'(voice_active), 32'h6C);

        // Reset while an event is pending
        ev.evt_ready = 1'b0;
        bus = set_slot(bus, 1, 1'b1, 3'd5, 7'd10);
        expect_evt("v1_pend", 3'd1, 1'b1, 7'd10, 3'd5);
        reset = 1'b1;
        #1;
        check("rst_emit_valid", 32'(ev.evt_valid), 0);
        check("rst_emit_active", 32'(voice_active), 0);
        tick();
        tick();
        reset        = 1'b0;
        ev.evt_ready = 1'b1;
        expect_evt("re_v1", 3'd1, 1'b1, 7'd10, 3'd5);
        tick();
        expect_evt("re_v2", 3'd2, 1'b1, 7'd64, 3'd1);
        tick();
        expect_evt("re_v3", 3'd3, 1'b1, 7'd50, 3'd0);
        tick();
        expect_evt("re_v5", 3'd5, 1'b1, 7'd67, 3'd3);
        tick();
        expect_evt("re_v6", 3'd6, 1'b1, 7'd72, 3'd4);
        tick();
        count_valid(20, c);
        check("re_done", 32'(c), 0);
        check("re_active", 32'(voice_active), 32'h6E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
